mux32_read_arbiter: RTL and testbench

Round-robin controller that shares one 32:1 word-select mux (the register-file read port) between several requesters. Each requester presents a 5-bit select with a valid/ready handshake. The arbiter grants one request, drives the mux select, captures the selected word and returns it on a single tagged response channel. It sits between the register-file storage/mux32 read path and the core units (decode, debug, CSR) that contend for that port.

---
 rtl/mux32_read_arbiter.sv | 106 ++++++++++
 tb/tb_mux32_read_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux32_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register-file read mux among REQS requesters.
// Each granted select is registered onto the mux, and the word comes back on a tagged response.
module mux32_read_arbiter #(
  parameter int N    = 32,
  parameter int REQS = 4,
  parameter int IDW  = $clog2(REQS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req_valid,
  input  logic [5*REQS-1:0] req_sel,
  output logic [REQS-1:0]   req_ready,
  output logic [4:0]        mux_s,
  input  logic [N-1:0]      mux_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [4:0]     sel_q;
  logic [IDW-1:0] id_q;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] ptr_next;
  logic           xfer;

  // Scan the requesters from rr_ptr upward with wrap. The first valid one found wins.
  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < REQS; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % REQS);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign ptr_next = (grant_idx == IDW'(REQS - 1)) ? '0 : grant_idx + IDW'(1);

  // rst gates the grant so that req_ready stays low while reset is held.
  assign xfer = rst && (state == IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (xfer) state_next = READ;
      READ:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      sel_q     <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (xfer) begin
        sel_q  <= req_sel[5*grant_idx +: 5];
        id_q   <= grant_idx;
        rr_ptr <= ptr_next;
      end
      if (state == READ) begin
        rsp_data  <= mux_out;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // The mux select comes only from a register, so it cannot glitch when req_sel changes.
  assign mux_s = sel_q;

endmodule

// File: tb/tb_mux32_read_arbiter.sv
// Directed bench for mux32_read_arbiter with a behavioural mux32 that returns in_k = 0xA5A50000 + k.
// Inputs are driven after each falling edge. Outputs are sampled 1 ns later, away from the rising edge.
module tb_mux32_read_arbiter;

  localparam int N    = 32;
  localparam int REQS = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [REQS-1:0]   req_valid;
  logic [5*REQS-1:0] req_sel;
  logic [REQS-1:0]   req_ready;
  logic [4:0]        mux_s;
  logic [N-1:0]      mux_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic              rsp_ready;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign mux_out = 32'hA5A5_0000 + {27'd0, mux_s};

  mux32_read_arbiter #(.N(N), .REQS(REQS), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .mux_s     (mux_s),
    .mux_out   (mux_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Walk one read through its three cycles, starting in the grant cycle.
  task automatic read_cycle(input string tag, input int id, input logic [4:0] sel);
    check({tag, " grant"}, 32'(req_ready), 32'(1 << id));
    step();
    check({tag, " mux_s"}, 32'(mux_s), 32'(sel));
    check({tag, " ready_read"}, 32'(req_ready), 32'd0);
    step();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, " rsp_data"}, rsp_data, 32'hA5A5_0000 + 32'(sel));
    step();
  endtask

  logic [31:0] held_data;
  logic [31:0] held_id;
  int          fair_id [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst       = 1'b0;
    req_valid = 4'hF;
    req_sel   = {5'd4, 5'd3, 5'd2, 5'd1};
    rsp_ready = 1'b1;

    // Reset held for two cycles with every request valid.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst mux_s", 32'(mux_s), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_data", rsp_data, 32'd0);
    end
    rst = 1'b1;
    #1;

    // Fairness: grants 0,1,2,3 and then 0 again, which shows the pointer wrapping from 3 to 0.
    for (int g = 0; g < 5; g++)
      read_cycle("fair", fair_id[g], 5'(fair_id[g] + 1));
    req_valid = 4'h0;
    #1;
    check("idle no grant", 32'(req_ready), 32'd0);

    // Single read: only requester 2 is valid, with sel 19. The pointer is 1 here.
    req_valid = 4'b0100;
    req_sel   = {5'd0, 5'd19, 5'd0, 5'd0};
    #1;
    read_cycle("single", 2, 5'd19);
    req_valid = 4'h0;
    #1;
    check("single idle rsp_valid", 32'(rsp_valid), 32'd0);

    // Backpressure: requester 0 reads sel 0, requester 1 waits with sel 31, and rsp_ready is held low.
    req_valid = 4'b0001;
    req_sel   = {5'd0, 5'd0, 5'd31, 5'd0};
    #1;
    check("bp grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("bp mux_s", 32'(mux_s), 32'd0);
    check("bp ready_read", 32'(req_ready), 32'd0);
    step();
    held_data = rsp_data;
    held_id   = 32'(rsp_id);
    check("bp rsp_data", held_data, 32'hA5A5_0000);
    check("bp rsp_id", held_id, 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("bp hold valid", 32'(rsp_valid), 32'd1);
      check("bp hold data", rsp_data, 32'hA5A5_0000);
      check("bp hold id", 32'(rsp_id), 32'd0);
      check("bp hold ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp last ready", 32'(req_ready), 32'd0);
    step();
    check("bp rsp dropped", 32'(rsp_valid), 32'd0);
    read_cycle("bp req1", 1, 5'd31);
    req_valid = 4'h0;
    #1;

    // Mid-operation reset: requester 3 is granted, and reset hits while the FSM is in READ.
    req_valid = 4'b1000;
    req_sel   = {5'd5, 5'd0, 5'd0, 5'd0};
    #1;
    check("mid grant3", 32'(req_ready), 32'b1000);
    step();
    check("mid mux_s", 32'(mux_s), 32'd5);
    rst       = 1'b0;
    req_valid = 4'h0;
    step();
    check("mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid mux_s rst", 32'(mux_s), 32'd0);
    check("mid rsp_data", rsp_data, 32'd0);
    step();
    check("mid rsp_valid2", 32'(rsp_valid), 32'd0);
    rst       = 1'b1;
    req_valid = 4'hF;
    req_sel   = {5'd4, 5'd3, 5'd2, 5'd7};
    #1;
    check("mid ptr0 grant", 32'(req_ready), 32'b0001);
    step();
    check("mid post mux_s", 32'(mux_s), 32'd7);
    check("mid post rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
